// File: rtl/dut_pattern_gen_if.sv
// dut_pattern_gen_if
// Bundles the configuration, run-control and status signals of the
// pattern generator so that the bench and the design share one definition.
//   master : drives configuration writes, XFER, START/STOP and NUM_CYCLES,
//            and observes pin drive, BUSY, BOUNDARY, DONE, CYC_COUNT, XFER_PEND.
//   slave  : the pattern generator itself.
interface dut_pattern_gen_if #(
    parameter int NPINS  = 128,
    parameter int NTSETS = 4,
    parameter int TW     = 8,
    parameter int CW     = 16
);
    localparam int SW = $clog2(NTSETS);

    logic             cfg_we;
    logic [2:0]       cfg_sel;
    logic [SW-1:0]    cfg_idx;
    logic [NPINS-1:0] cfg_wdata;
    logic             xfer;
    logic             start;
    logic             stop;
    logic [CW-1:0]    num_cycles;
    logic [NPINS-1:0] pin_out;
    logic             busy;
    logic             boundary;
    logic             done;
    logic [CW-1:0]    cyc_count;
    logic             xfer_pend;

    modport master (
        output cfg_we, cfg_sel, cfg_idx, cfg_wdata, xfer, start, stop, num_cycles,
        input  pin_out, busy, boundary, done, cyc_count, xfer_pend
    );

    modport slave (
        input  cfg_we, cfg_sel, cfg_idx, cfg_wdata, xfer, start, stop, num_cycles,
        output pin_out, busy, boundary, done, cyc_count, xfer_pend
    );
endinterface

// File: rtl/dut_pattern_gen.sv
// dut_pattern_gen
// Drives NPINS tester pins from per-pin data, drive format (OFF/NRZ/RZ/R1)
// and timing-set selection. Each of the NTSETS timing sets holds a lead and
// a trail edge; a global period sets the tester-cycle length. Configuration
// is written to a shadow copy and committed to the active copy by XFER,
// immediately when idle or at the next cycle boundary when running.
// Ports:
//   clk - system clock
//   rst - asynchronous active-high reset
//   bus - dut_pattern_gen_if slave: config writes, XFER, START/STOP,
//         NUM_CYCLES in; PIN_OUT, BUSY, BOUNDARY, DONE, CYC_COUNT, XFER_PEND out
module dut_pattern_gen #(
    parameter int NPINS  = 128,
    parameter int NTSETS = 4,
    parameter int TW     = 8,
    parameter int CW     = 16
) (
    input logic              clk,
    input logic              rst,
    dut_pattern_gen_if.slave bus
);
    localparam int SW = $clog2(NTSETS);

    typedef enum logic {IDLE, RUN} state_t;

    logic [NPINS-1:0]          data_sh, fmt0_sh, fmt1_sh;
    logic [SW-1:0][NPINS-1:0]  tsel_sh;
    logic [NTSETS-1:0][TW-1:0] lead_sh, trail_sh;
    logic [TW-1:0]             period_sh;

    logic [NPINS-1:0]          data_act, fmt0_act, fmt1_act;
    logic [SW-1:0][NPINS-1:0]  tsel_act;
    logic [NTSETS-1:0][TW-1:0] lead_act, trail_act;
    logic [TW-1:0]             period_act;

    state_t           state;
    logic [TW-1:0]    ph;
    logic [CW-1:0]    num_lat;
    logic             stop_req;
    logic [NPINS-1:0] pin_r;
    logic             busy_r, boundary_r, done_r, pend_r;
    logic [CW-1:0]    cyc_r;

    logic [TW-1:0]    p_eff;
    logic             last_ph;
    logic [CW-1:0]    cyc_inc;
    logic             run_exit;
    logic             commit;
    logic [NPINS-1:0] wave, idle_pin;

    // Cycle bookkeeping. A period of 0 behaves like 1 so the phase counter
    // always wraps. A transfer requested on the very edge a run ends is
    // committed there, otherwise it would be left pending in IDLE.
    always_comb begin
        p_eff    = (period_act == '0) ? TW'(1) : period_act;
        last_ph  = (ph == p_eff - TW'(1));
        cyc_inc  = cyc_r + CW'(1);
        run_exit = stop_req || bus.stop || ((num_lat != '0) && (cyc_inc == num_lat));
        commit   = ((state == IDLE) && bus.xfer) ||
                   ((state == RUN) && last_ph && (pend_r || (bus.xfer && run_exit)));
    end

    // Per-pin waveform for the current phase, plus the level a pin takes
    // when an idle transfer switches it to a returning format (evaluated as
    // if the phase were past the end of the cycle, i.e. the return level).
    always_comb begin
        logic [SW-1:0] s;
        logic [TW-1:0] lo, hi;
        logic          hit, win;
        wave     = '0;
        idle_pin = pin_r;
        s        = '0;
        lo       = '0;
        hi       = '0;
        hit      = 1'b0;
        win      = 1'b0;
        for (int i = 0; i < NPINS; i++) begin
            for (int b = 0; b < SW; b++) begin
                s[b] = tsel_act[b][i];
            end
            lo  = lead_act[s];
            hi  = trail_act[s];
            hit = (ph == lo);
            win = (ph >= lo) && (ph < hi);
            case ({fmt1_act[i], fmt0_act[i]})
                2'b00:   wave[i] = 1'b0;
                2'b01:   wave[i] = hit ? data_act[i] : pin_r[i];
                2'b10:   wave[i] = win & data_act[i];
                default: wave[i] = win ? data_act[i] : 1'b1;
            endcase
            if ({fmt1_sh[i], fmt0_sh[i]} != {fmt1_act[i], fmt0_act[i]}) begin
                case ({fmt1_sh[i], fmt0_sh[i]})
                    2'b00, 2'b10: idle_pin[i] = 1'b0;
                    2'b11:        idle_pin[i] = 1'b1;
                    default:      idle_pin[i] = pin_r[i];
                endcase
            end
        end
    end

    // Shadow configuration writes. Tset-select plane indices beyond the
    // number of select bits are dropped.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_sh   <= '0;
            fmt0_sh   <= '0;
            fmt1_sh   <= '0;
            tsel_sh   <= '0;
            lead_sh   <= '0;
            trail_sh  <= '0;
            period_sh <= '0;
        end else if (bus.cfg_we) begin
            case (bus.cfg_sel)
                3'd0: data_sh <= bus.cfg_wdata;
                3'd1: fmt0_sh <= bus.cfg_wdata;
                3'd2: fmt1_sh <= bus.cfg_wdata;
                3'd3: if (int'(bus.cfg_idx) < SW) tsel_sh[bus.cfg_idx] <= bus.cfg_wdata;
                3'd4: begin
                    lead_sh[bus.cfg_idx]  <= bus.cfg_wdata[TW-1:0];
                    trail_sh[bus.cfg_idx] <= bus.cfg_wdata[2*TW-1:TW];
                end
                3'd5: period_sh <= bus.cfg_wdata[TW-1:0];
                default: ;
            endcase
        end
    end

    // Active configuration; commits see the shadow before any same-edge write.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_act   <= '0;
            fmt0_act   <= '0;
            fmt1_act   <= '0;
            tsel_act   <= '0;
            lead_act   <= '0;
            trail_act  <= '0;
            period_act <= '0;
        end else if (commit) begin
            data_act   <= data_sh;
            fmt0_act   <= fmt0_sh;
            fmt1_act   <= fmt1_sh;
            tsel_act   <= tsel_sh;
            lead_act   <= lead_sh;
            trail_act  <= trail_sh;
            period_act <= period_sh;
        end
    end

    // Run engine. BOUNDARY is high during every clock in which PH is 0 of a
    // running cycle; DONE follows the last phase of the final cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            ph         <= '0;
            num_lat    <= '0;
            stop_req   <= 1'b0;
            pin_r      <= '0;
            busy_r     <= 1'b0;
            boundary_r <= 1'b0;
            done_r     <= 1'b0;
            pend_r     <= 1'b0;
            cyc_r      <= '0;
        end else begin
            boundary_r <= 1'b0;
            done_r     <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.xfer) pin_r <= idle_pin;
                    if (bus.start) begin
                        state      <= RUN;
                        busy_r     <= 1'b1;
                        boundary_r <= 1'b1;
                        ph         <= '0;
                        cyc_r      <= '0;
                        num_lat    <= bus.num_cycles;
                        stop_req   <= 1'b0;
                    end
                end
                default: begin
                    pin_r <= wave;
                    if (bus.stop) stop_req <= 1'b1;
                    if (last_ph) begin
                        ph     <= '0;
                        cyc_r  <= cyc_inc;
                        pend_r <= !commit && bus.xfer;
                        if (run_exit) begin
                            state    <= IDLE;
                            busy_r   <= 1'b0;
                            done_r   <= 1'b1;
                            stop_req <= 1'b0;
                        end else begin
                            boundary_r <= 1'b1;
                        end
                    end else begin
                        ph <= ph + TW'(1);
                        if (bus.xfer) pend_r <= 1'b1;
                    end
                end
            endcase
        end
    end

    assign bus.pin_out   = pin_r;
    assign bus.busy      = busy_r;
    assign bus.boundary  = boundary_r;
    assign bus.done      = done_r;
    assign bus.cyc_count = cyc_r;
    assign bus.xfer_pend = pend_r;
endmodule

// File: tb/tb_dut_pattern_gen.sv
// tb_dut_pattern_gen
// Self-checking bench for dut_pattern_gen. Runs are predicted clock by clock
// from a small reference of the pin formats and pushed to a scoreboard when
// START is driven; a negedge monitor pops and compares each clock.
module tb_dut_pattern_gen;
    localparam int NPINS  = 128;
    localparam int NTSETS = 4;
    localparam int TW     = 8;
    localparam int CW     = 16;

    typedef struct {
        logic [2:0]    pin;
        logic          busy;
        logic          bnd;
        logic          done;
        logic [CW-1:0] cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   rec_no = 0;

    // Reference copy of the committed configuration for pins 0..2.
    logic [1:0] m_fmt[3];
    logic       m_d[3];
    int         m_ts[3];
    int         m_lead[NTSETS];
    int         m_trail[NTSETS];
    logic [2:0] m_pin;

    always #5 clk = ~clk;

    dut_pattern_gen_if #(.NPINS(NPINS), .NTSETS(NTSETS), .TW(TW), .CW(CW)) bus ();

    dut_pattern_gen #(.NPINS(NPINS), .NTSETS(NTSETS), .TW(TW), .CW(CW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic modelPin(input logic [1:0] f, input logic d, input int lo,
                                      input int hi, input int t, input logic prev);
        case (f)
            2'b00:   return 1'b0;
            2'b01:   return (t == lo) ? d : prev;
            2'b10:   return (t >= lo && t < hi) ? d : 1'b0;
            default: return (t >= lo && t < hi) ? d : 1'b1;
        endcase
    endfunction

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic cfgWrite(input logic [2:0] sel, input int idx, input logic [NPINS-1:0] wdata);
        bus.cfg_we    = 1'b1;
        bus.cfg_sel   = sel;
        bus.cfg_idx   = idx[1:0];
        bus.cfg_wdata = wdata;
        tick();
        bus.cfg_we    = 1'b0;
    endtask

    task automatic doXfer();
        bus.xfer = 1'b1;
        tick();
        bus.xfer = 1'b0;
    endtask

    // Predicts a whole run (period p, ncyc cycles) into the scoreboard, then
    // drives START. Pin 0 data may change from cycle chg_cycle onward.
    task automatic applyStimulus(input int p, input int ncyc, input int num_in,
                                 input int chg_cycle, input logic chg_d0, input bit extra);
        logic [2:0] prev;
        int         total, g, c, t;
        logic       d;
        exp_t       e;
        prev  = m_pin;
        total = p * ncyc;
        for (int k = 0; k <= total; k++) begin
            if (k > 0) begin
                g = k - 1;
                c = g / p;
                t = g % p;
                for (int i = 0; i < 3; i++) begin
                    d = m_d[i];
                    if (i == 0 && chg_cycle >= 0 && c >= chg_cycle) d = chg_d0;
                    prev[i] = modelPin(m_fmt[i], d, m_lead[m_ts[i]], m_trail[m_ts[i]], t, prev[i]);
                end
            end
            e.pin  = prev;
            e.busy = (k < total);
            e.bnd  = (k < total) && (k % p == 0);
            e.done = (k == total);
            e.cyc  = CW'(k / p);
            sb.push_back(e);
        end
        if (extra) begin
            e.pin  = prev;
            e.busy = 1'b0;
            e.bnd  = 1'b0;
            e.done = 1'b0;
            e.cyc  = CW'(ncyc);
            sb.push_back(e);
        end
        m_pin = prev;
        if (chg_cycle >= 0) m_d[0] = chg_d0;
        bus.num_cycles = CW'(num_in);
        bus.start      = 1'b1;
        tick();
        bus.start      = 1'b0;
    endtask

    task automatic waitDrain(input int maxc, input string tag);
        int n;
        n = 0;
        while (sb.size() > 0 && n < maxc) begin
            tick();
            n++;
        end
        if (sb.size() > 0) begin
            checkOutput({tag, " drain timeout"}, 32'(sb.size()), 32'd0);
            sb.delete();
        end
    endtask

    // Scoreboard monitor, sampling half a clock after the active edge.
    always @(negedge clk) begin
        if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            checkOutput($sformatf("rec%0d pin", rec_no), 32'(bus.pin_out[2:0]), 32'(e.pin));
            checkOutput($sformatf("rec%0d busy", rec_no), 32'(bus.busy), 32'(e.busy));
            checkOutput($sformatf("rec%0d boundary", rec_no), 32'(bus.boundary), 32'(e.bnd));
            checkOutput($sformatf("rec%0d done", rec_no), 32'(bus.done), 32'(e.done));
            checkOutput($sformatf("rec%0d cyc_count", rec_no), 32'(bus.cyc_count), 32'(e.cyc));
            rec_no++;
        end
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int n;
        rst            = 1'b1;
        bus.cfg_we     = 1'b0;
        bus.cfg_sel    = '0;
        bus.cfg_idx    = '0;
        bus.cfg_wdata  = '0;
        bus.xfer       = 1'b0;
        bus.start      = 1'b0;
        bus.stop       = 1'b0;
        bus.num_cycles = '0;
        for (int i = 0; i < 3; i++) begin
            m_fmt[i] = 2'b00;
            m_d[i]   = 1'b0;
            m_ts[i]  = 0;
        end
        for (int i = 0; i < NTSETS; i++) begin
            m_lead[i]  = 0;
            m_trail[i] = 0;
        end
        m_pin = 3'b000;
        repeat (3) tick();
        rst = 1'b0;
        tick();

        // Reset in the middle of a free run.
        cfgWrite(3'd5, 0, NPINS'(10));
        cfgWrite(3'd4, 0, NPINS'(16'h0703));
        cfgWrite(3'd0, 0, NPINS'(1));
        cfgWrite(3'd1, 0, NPINS'(1));
        doXfer();
        bus.num_cycles = '0;
        bus.start      = 1'b1;
        tick();
        bus.start      = 1'b0;
        repeat (15) tick();
        checkOutput("t1 busy before reset", 32'(bus.busy), 32'd1);
        checkOutput("t1 pin0 before reset", 32'(bus.pin_out[0]), 32'd1);
        rst = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            checkOutput("t1 done in reset", 32'(bus.done), 32'd0);
            checkOutput("t1 busy in reset", 32'(bus.busy), 32'd0);
        end
        checkOutput("t1 pin_out any", 32'(|bus.pin_out), 32'd0);
        checkOutput("t1 cyc_count", 32'(bus.cyc_count), 32'd0);
        checkOutput("t1 xfer_pend", 32'(bus.xfer_pend), 32'd0);
        checkOutput("t1 boundary", 32'(bus.boundary), 32'd0);
        rst = 1'b0;
        tick();
        doXfer();
        tick();
        checkOutput("t1 idle xfer pin_out any", 32'(|bus.pin_out), 32'd0);
        checkOutput("t1 idle busy", 32'(bus.busy), 32'd0);
        checkOutput("t1 idle done", 32'(bus.done), 32'd0);

        // NRZ run of two cycles.
        cfgWrite(3'd5, 0, NPINS'(10));
        cfgWrite(3'd4, 0, NPINS'(16'h0703));
        cfgWrite(3'd0, 0, NPINS'(1));
        cfgWrite(3'd1, 0, NPINS'(1));
        doXfer();
        m_lead[0] = 3; m_trail[0] = 7; m_d[0] = 1'b1; m_fmt[0] = 2'b01;
        applyStimulus(10, 2, 2, -1, 1'b0, 1'b1);
        waitDrain(40, "t2");
        checkOutput("t2 upper pins idle", 32'(|bus.pin_out[NPINS-1:3]), 32'd0);

        // RZ/R1 pins on timing set 1; the transfer shares its clock with a
        // period write, so the first run still uses the old period of 10.
        cfgWrite(3'd4, 1, NPINS'(16'h0502));
        cfgWrite(3'd0, 0, NPINS'(3'b011));
        cfgWrite(3'd1, 0, NPINS'(3'b101));
        cfgWrite(3'd2, 0, NPINS'(3'b110));
        cfgWrite(3'd3, 0, NPINS'(3'b110));
        bus.cfg_we    = 1'b1;
        bus.cfg_sel   = 3'd5;
        bus.cfg_idx   = '0;
        bus.cfg_wdata = NPINS'(8);
        bus.xfer      = 1'b1;
        tick();
        bus.cfg_we    = 1'b0;
        bus.xfer      = 1'b0;
        checkOutput("t3 idle xfer return levels", 32'(bus.pin_out[2:0]), 32'b101);
        m_pin = 3'b101;
        m_lead[1] = 2; m_trail[1] = 5;
        m_d[1] = 1'b1; m_d[2] = 1'b0;
        m_fmt[1] = 2'b10; m_fmt[2] = 2'b11;
        m_ts[1] = 1; m_ts[2] = 1;
        applyStimulus(10, 1, 1, -1, 1'b0, 1'b1);
        waitDrain(30, "t3a");
        doXfer();
        applyStimulus(8, 2, 2, -1, 1'b0, 1'b1);
        waitDrain(30, "t3b");

        // Transfer requested mid-cycle is held until the boundary.
        cfgWrite(3'd5, 0, NPINS'(10));
        doXfer();
        applyStimulus(10, 2, 2, 1, 1'b0, 1'b1);
        repeat (4) tick();
        bus.cfg_we    = 1'b1;
        bus.cfg_sel   = 3'd0;
        bus.cfg_wdata = NPINS'(3'b010);
        tick();
        bus.cfg_we    = 1'b0;
        bus.xfer      = 1'b1;
        tick();
        bus.xfer      = 1'b0;
        checkOutput("t4 pend after xfer", 32'(bus.xfer_pend), 32'd1);
        for (int i = 0; i < 3; i++) begin
            tick();
            checkOutput("t4 pend held", 32'(bus.xfer_pend), 32'd1);
        end
        tick();
        checkOutput("t4 pend cleared at boundary", 32'(bus.xfer_pend), 32'd0);
        waitDrain(30, "t4");

        // Free run stopped at phase 2 of cycle 5.
        applyStimulus(10, 6, 0, -1, 1'b0, 1'b0);
        repeat (52) tick();
        bus.stop = 1'b1;
        tick();
        bus.stop = 1'b0;
        waitDrain(20, "t5");
        bus.num_cycles = CW'(1);
        bus.start      = 1'b1;
        tick();
        bus.start      = 1'b0;
        checkOutput("t5 restart busy", 32'(bus.busy), 32'd1);
        checkOutput("t5 restart boundary", 32'(bus.boundary), 32'd1);
        checkOutput("t5 restart cyc_count", 32'(bus.cyc_count), 32'd0);
        n = 0;
        while (!bus.done && n < 20) begin
            tick();
            n++;
        end
        checkOutput("t5 restart done", 32'(bus.done), 32'd1);
        checkOutput("t5 restart cycles", 32'(bus.cyc_count), 32'd1);
        tick();

        // Lead beyond the period, and an empty RZ window.
        cfgWrite(3'd4, 2, NPINS'(16'h0E0C));
        cfgWrite(3'd4, 3, NPINS'(16'h0404));
        cfgWrite(3'd0, 0, NPINS'(3'b011));
        cfgWrite(3'd3, 1, NPINS'(3'b011));
        doXfer();
        m_lead[2] = 12; m_trail[2] = 14;
        m_lead[3] = 4;  m_trail[3] = 4;
        m_d[0] = 1'b1;
        m_ts[0] = 2; m_ts[1] = 3;
        applyStimulus(10, 1, 1, -1, 1'b0, 1'b1);
        waitDrain(20, "t6a");
        checkOutput("t6 nrz lead beyond period", 32'(bus.pin_out[0]), 32'd0);
        checkOutput("t6 rz empty window", 32'(bus.pin_out[1]), 32'd0);

        // Period 0: every clock is a boundary.
        cfgWrite(3'd5, 0, NPINS'(0));
        doXfer();
        applyStimulus(1, 3, 3, -1, 1'b0, 1'b1);
        waitDrain(10, "t6b");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
